cic_decimator_param: RTL and testbench

CIC_DECIMATOR_PARAM -- requirements
Module: cic_decimator_param

---
 rtl/cic_decimator_param.sv | 141 ++++++++++++++
 tb/tb_cic_decimator_param.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator_param.sv
// Parameterised CIC decimator: ORDER integrators at input rate, ORDER combs at tick rate, R = 2^dec_log2.
// Optional macro CIC_GAIN_NORM_EN divides the output by R^ORDER (arithmetic shift); latency is unchanged.
module cic_decimator_param #(
    parameter int IN_W      = 32,
    parameter int ORDER     = 2,
    parameter int LOG2_RMAX = 8,
    localparam int ACC_W    = IN_W + ORDER * LOG2_RMAX,
    localparam int RW       = $clog2(LOG2_RMAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  xin,
    input  logic                    in_valid,
    input  logic [RW-1:0]           dec_log2,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_valid,
    output logic [RW-1:0]           ratio_active
);

    logic signed [ACC_W-1:0] integ_q [ORDER];
    logic signed [ACC_W-1:0] integ_d [ORDER];
    logic signed [ACC_W-1:0] comb_q  [ORDER];
    logic signed [ACC_W-1:0] comb_d  [ORDER];
    logic signed [ACC_W-1:0] dly_q   [ORDER];
    logic signed [ACC_W-1:0] dly_d   [ORDER];
    logic signed [ACC_W-1:0] stage_in [ORDER];
    logic [ORDER-1:0]        stage_vin;
    logic [ORDER-1:0]        comb_vld_q, comb_vld_d;
    logic [LOG2_RMAX-1:0]    cnt_q, cnt_d, cnt_last;
    logic [RW-1:0]           ratio_q, ratio_d, dec_clamped;
    logic signed [ACC_W-1:0] samp_q, samp_d;
    logic                    samp_vld_q, samp_vld_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d, comb_res;
    logic                    out_vld_q, out_vld_d;
    logic                    tick;

    assign dec_clamped = (int'(dec_log2) > LOG2_RMAX) ? RW'(LOG2_RMAX) : dec_log2;
    assign cnt_last    = LOG2_RMAX'((32'd1 << ratio_q) - 32'd1);
    assign tick        = in_valid && (cnt_q == cnt_last);

    // Integrator chain is combinationally cascaded so the last stage already includes the tick sample.
    always_comb begin
        integ_d    = integ_q;
        cnt_d      = cnt_q;
        ratio_d    = ratio_q;
        samp_d     = samp_q;
        samp_vld_d = tick;
        if (in_valid) begin
            integ_d[0] = integ_q[0] + ACC_W'(xin);
            for (int i = 1; i < ORDER; i++) begin
                integ_d[i] = integ_q[i] + integ_d[i-1];
            end
            cnt_d = tick ? '0 : cnt_q + LOG2_RMAX'(1);
        end
        if (tick) begin
            samp_d  = integ_d[ORDER-1];
            ratio_d = dec_clamped;
        end
    end

    // Tokens advance one stage every cycle, so back-to-back ticks never collide.
    always_comb begin
        stage_in[0]  = samp_q;
        stage_vin[0] = samp_vld_q;
        for (int i = 1; i < ORDER; i++) begin
            stage_in[i]  = comb_q[i-1];
            stage_vin[i] = comb_vld_q[i-1];
        end
        comb_d     = comb_q;
        dly_d      = dly_q;
        comb_vld_d = stage_vin;
        for (int i = 0; i < ORDER; i++) begin
            if (stage_vin[i]) begin
                comb_d[i] = stage_in[i] - dly_q[i];
                dly_d[i]  = stage_in[i];
            end
        end
    end

`ifdef CIC_GAIN_NORM_EN
    // Each token carries the ratio of the frame it closed, since ratio_q may already have moved on.
    logic [RW-1:0] samp_sh_q;
    logic [RW-1:0] sh_q [ORDER];
    logic [RW-1:0] sh_d [ORDER];

    always_comb begin
        sh_d[0] = samp_sh_q;
        for (int i = 1; i < ORDER; i++) begin
            sh_d[i] = sh_q[i-1];
        end
        comb_res = comb_q[ORDER-1] >>> (ORDER * int'(sh_q[ORDER-1]));
    end

    always_ff @(posedge clk) begin
        samp_sh_q <= ratio_q;
        for (int i = 0; i < ORDER; i++) begin
            sh_q[i] <= sh_d[i];
        end
    end
`else
    assign comb_res = comb_q[ORDER-1];
`endif

    always_comb begin
        out_vld_d  = comb_vld_q[ORDER-1];
        out_data_d = comb_vld_q[ORDER-1] ? comb_res : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= '0;
                comb_q[i]  <= '0;
                dly_q[i]   <= '0;
            end
            comb_vld_q <= '0;
            cnt_q      <= '0;
            ratio_q    <= dec_clamped;
            samp_q     <= '0;
            samp_vld_q <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            integ_q    <= integ_d;
            comb_q     <= comb_d;
            dly_q      <= dly_d;
            comb_vld_q <= comb_vld_d;
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            samp_q     <= samp_d;
            samp_vld_q <= samp_vld_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_vld_q;
    assign ratio_active = ratio_q;

endmodule

// File: tb/tb_cic_decimator_param.sv
// Bench for cic_decimator_param: cumulative-sum / binomial-difference reference model with a timed scoreboard.
module tb_cic_decimator_param;

    localparam int IN_W  = 32, ORDER  = 2, L  = 8, ACC_W  = 48, RW  = 4;
    localparam int IN_W1 = 8,  ORDER1 = 1, L1 = 2, ACC_W1 = 10, RW1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset, in_valid;
    logic signed [IN_W-1:0]  xin;
    logic [RW-1:0]           dec_log2, ratio_active;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_valid;

    logic                     reset_1, in_valid_1;
    logic signed [IN_W1-1:0]  xin_1;
    logic [RW1-1:0]           dec_log2_1, ratio_active_1;
    logic signed [ACC_W1-1:0] out_data_1;
    logic                     out_valid_1;

    cic_decimator_param #(.IN_W(IN_W), .ORDER(ORDER), .LOG2_RMAX(L)) dut (
        .clk(clk), .reset(reset), .xin(xin), .in_valid(in_valid), .dec_log2(dec_log2),
        .out_data(out_data), .out_valid(out_valid), .ratio_active(ratio_active)
    );

    cic_decimator_param #(.IN_W(IN_W1), .ORDER(ORDER1), .LOG2_RMAX(L1)) dut1 (
        .clk(clk), .reset(reset_1), .xin(xin_1), .in_valid(in_valid_1), .dec_log2(dec_log2_1),
        .out_data(out_data_1), .out_valid(out_valid_1), .ratio_active(ratio_active_1)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        longint val;
        int     due;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];

    longint m_acc [ORDER];
    longint m_hist [ORDER+1];
    int     m_cnt, m_ratio;
    int     cyc = 0, c1 = 0;
    int     exp_ratio = 0;
    longint last_exp = 0, obs_last = 0;
    bit     mon_en = 0, mon1_en = 0;

    function automatic longint wrap(input longint v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'(t);
    endfunction

    function automatic int clampd(input int d);
        return (d > L) ? L : d;
    endfunction

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // Model: ideal ORDER-fold running sums, sampled every R-th accepted input, then ORDER-th difference.
    task automatic step(input bit rst_n, input bit v, input longint x, input int d);
        exp_t   e;
        longint y;
        @(negedge clk);
        #1;
        reset    = rst_n;
        in_valid = v;
        xin      = x[IN_W-1:0];
        dec_log2 = d[RW-1:0];
        if (!rst_n) begin
            for (int i = 0; i < ORDER; i++) m_acc[i] = 0;
            for (int i = 0; i <= ORDER; i++) m_hist[i] = 0;
            m_cnt    = 0;
            m_ratio  = clampd(d);
            last_exp = 0;
            q.delete();
        end else if (v) begin
            m_acc[0] += x;
            for (int i = 1; i < ORDER; i++) m_acc[i] += m_acc[i-1];
            if (m_cnt == (1 << m_ratio) - 1) begin
                for (int k = ORDER; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = m_acc[ORDER-1];
                y = 0;
                for (int k = 0; k <= ORDER; k++)
                    y += ((k % 2) ? -binom(ORDER, k) : binom(ORDER, k)) * m_hist[k];
`ifdef CIC_GAIN_NORM_EN
                y = y >>> (ORDER * m_ratio);
`endif
                e.val = wrap(y);
                e.due = cyc + 1 + ORDER + 1;
                q.push_back(e);
                m_cnt   = 0;
                m_ratio = clampd(d);
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        cyc++;
        exp_ratio = m_ratio;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("ratio_active", ratio_active, exp_ratio);
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("missed_vld_due", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (out_valid) begin
                obs_last = out_data;
                if (q.size() == 0) begin
                    chk("spurious_vld", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.val);
                    chk("vld_timing", cyc, e.due);
                    last_exp = e.val;
                end
            end else begin
                chk("hold", out_data, last_exp);
            end
        end
    end

    task automatic step1(input bit rst_n, input bit v, input int x);
        @(negedge clk);
        #1;
        reset_1    = rst_n;
        in_valid_1 = v;
        xin_1      = IN_W1'(x);
        dec_log2_1 = 2'd2;
        @(posedge clk);
        c1++;
    endtask

    always @(negedge clk) begin
        if (mon1_en && out_valid_1) begin
            exp_t e;
            if (q1.size() == 0) begin
                chk("o1_spurious_vld", out_valid_1, 0);
            end else begin
                e = q1.pop_front();
                chk("o1_data", out_data_1, e.val);
                chk("o1_timing", c1, e.due);
            end
        end
    end

    initial begin
        exp_t   e;
        int     acc_n;
        longint mn;
        reset = 1'b0; in_valid = 1'b0; xin = '0; dec_log2 = '0;
        reset_1 = 1'b0; in_valid_1 = 1'b0; xin_1 = '0; dec_log2_1 = '0;

        // ORDER=1, R=4: impulse then zeros; first output 3 cycles after the 4th accepted input.
        step1(0, 0, 0);
        step1(0, 0, 0);
        mon1_en = 1;
        acc_n = 0;
        for (int i = 0; i < 16; i++) begin
            acc_n++;
            if (acc_n % 4 == 0) begin
`ifdef CIC_GAIN_NORM_EN
                e.val = 0;
`else
                e.val = (acc_n == 4) ? 1 : 0;
`endif
                e.due = c1 + 1 + ORDER1 + 1;
                q1.push_back(e);
            end
            step1(1, 1, (i == 0) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) step1(1, 0, 0);
        chk("o1_drain", q1.size(), 0);

        // Reset state of the main instance.
        step(0, 0, 0, 2);
        mon_en = 1;
        step(0, 0, 0, 2);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ratio", ratio_active, 2);

        // DC input of 1 with R=4.
        for (int i = 0; i < 40; i++) step(1, 1, 1, 2);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 2);
`ifdef CIC_GAIN_NORM_EN
        chk("dc_r4", obs_last, 1);
`else
        chk("dc_r4", obs_last, 16);
`endif

        // in_valid toggling with R=2 and constant input.
        step(0, 0, 0, 1);
        for (int i = 0; i < 32; i++) step(1, (i % 2) == 0, 5, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
`ifdef CIC_GAIN_NORM_EN
        chk("dc_toggle", obs_last, 5);
`else
        chk("dc_toggle", obs_last, 20);
`endif

        // Mid-frame ratio change 2 -> 3.
        step(0, 0, 0, 2);
        for (int i = 0; i < 40; i++)
            step(1, 1, longint'($urandom_range(0, 2000)) - 1000, (i < 6) ? 2 : 3);

        // Reset pulse mid-pipeline, then a fresh run.
        for (int i = 0; i < 10; i++) step(1, 1, longint'($urandom_range(0, 2000)) - 1000, 2);
        step(0, 0, 0, 2);
        for (int i = 0; i < 20; i++) step(1, 1, 7 * i - 30, 2);

        // R=1 passes the input through.
        step(0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step(1, $urandom_range(0, 1) == 1, longint'($urandom_range(0, 200)) - 100, 0);

        // Clamped ratio with the most negative input held.
        step(0, 0, 0, 15);
        #2;
        chk("clamp_ratio", ratio_active, L);
        mn = -(longint'(1) << (IN_W - 1));
        for (int i = 0; i < 256 * 3 + 8; i++) step(1, 1, mn, 15);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 15);
`ifdef CIC_GAIN_NORM_EN
        chk("min_dc_wrap", obs_last, mn);
`else
        chk("min_dc_wrap", obs_last, mn * (longint'(1) << (2 * L)));
`endif

        // Random valid pattern with frequently changing ratio.
        step(0, 0, 0, 1);
        for (int i = 0; i < 200; i++)
            step(1, $urandom_range(0, 3) != 0, longint'($urandom) - 64'sd2147483648,
                 $urandom_range(0, 3));
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
        chk("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
